// File: rtl/bsg_rr_scan_arb_pkg.sv
// Shared types for the round-robin scan arbiter: FSM state and id-width helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package bsg_rr_scan_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_e;

    // Width of a binary requester index; a single requester still gets one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bsg_rr_scan_arb_if.sv
// Request/grant bundle between requesters, arbiter and the consumer of the grant.
// Latency: n/a (wires only).
// Backpressure: grant is held until yumi_i; master = arbiter side, slave = requesters/consumer side.
interface bsg_rr_scan_arb_if #(
    parameter int width_p = 4
);
    import bsg_rr_scan_arb_pkg::*;

    localparam int id_w = id_width(width_p);

    logic [width_p-1:0] reqs_i;
    logic [width_p-1:0] grants_o;
    logic [id_w-1:0]    grant_id_o;
    logic               grant_v_o;
    logic               yumi_i;

    modport master (
        input  reqs_i,
        input  yumi_i,
        output grants_o,
        output grant_id_o,
        output grant_v_o
    );

    modport slave (
        output reqs_i,
        output yumi_i,
        input  grants_o,
        input  grant_id_o,
        input  grant_v_o
    );

endinterface

// File: rtl/bsg_rr_scan_pick.sv
// Rotating-priority find-first: lowest request at or above ptr_i, else lowest overall.
// Latency: combinational.
// Backpressure: none.
// Ports: ptr_i = priority pointer, reqs_i = requests, pick_o = one-hot winner, any_o = some request.
module bsg_rr_scan_pick #(
    parameter int width_p = 4,
    parameter int id_w    = 2
) (
    input  logic [id_w-1:0]    ptr_i,
    input  logic [width_p-1:0] reqs_i,
    output logic [width_p-1:0] pick_o,
    output logic               any_o
);

    logic [width_p-1:0] one;
    logic [width_p-1:0] ptr_oh;
    logic [width_p-1:0] pmask;
    logic [width_p-1:0] hi;
    logic [width_p-1:0] src;
    logic [width_p-1:0] src_scan;

    assign one    = width_p'(1);
    assign ptr_oh = one << ptr_i;

    // Bits at or above the pointer.
    bsg_scan #(.width_p(width_p), .or_p(1), .lo_to_hi_p(1)) mask_scan (
        .i (ptr_oh),
        .o (pmask)
    );

    assign hi  = reqs_i & pmask;
    // Nothing at or above the pointer: wrap and search from bit 0.
    assign src = (|hi) ? hi : reqs_i;

    bsg_scan #(.width_p(width_p), .or_p(1), .lo_to_hi_p(1)) ffs_scan (
        .i (src),
        .o (src_scan)
    );

    // A bit survives only if no lower bit of src is set.
    assign pick_o = src & ~(src_scan << 1);
    assign any_o  = |reqs_i;

endmodule

// File: rtl/bsg_scan.sv
// Log-depth prefix scan (OR or AND) in either direction.
// Latency: combinational.
// Backpressure: none.
// Ports: i = input vector, o = scanned vector (lo_to_hi: o[k] = op of i[0..k]).
module bsg_scan #(
    parameter int width_p    = 4,
    parameter int or_p       = 1,
    parameter int lo_to_hi_p = 1
) (
    input  logic [width_p-1:0] i,
    output logic [width_p-1:0] o
);

    logic [width_p-1:0] t;
    logic [width_p-1:0] sh;
    logic [width_p-1:0] fill;

    // Kogge-Stone style doubling: after the stage with shift s, each bit
    // covers a window of 2*s inputs.
    always_comb begin
        t    = i;
        sh   = '0;
        fill = '0;
        for (int s = 1; s < width_p; s = s * 2) begin
            if (lo_to_hi_p != 0) begin
                sh   = t << s;
                fill = ~({width_p{1'b1}} << s);
            end else begin
                sh   = t >> s;
                fill = ~({width_p{1'b1}} >> s);
            end
            if (or_p != 0) t = t | sh;
            else           t = t & (sh | fill);
        end
        o = t;
    end

endmodule

// File: rtl/bsg_rr_scan_arb.sv
// Registered round-robin arbiter: one-hot grant from rotating-priority scan pick.
// Latency: request in IDLE -> grant_v_o next cycle; one accepted grant per cycle sustained.
// Backpressure: offered grant held stable until yumi_i; requests must hold until served.
// Ports: clk_i, reset_n_i (sync, active-low), bus (reqs_i/yumi_i in; grants_o/grant_id_o/grant_v_o out).
module bsg_rr_scan_arb
    import bsg_rr_scan_arb_pkg::*;
#(
    parameter int width_p        = 4,
    parameter int lo_pri_reset_p = 0
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    bsg_rr_scan_arb_if.master bus
);

    localparam int id_w = id_width(width_p);

    arb_state_e         state_r, state_n;
    logic [width_p-1:0] grant_r, grant_n;
    logic [id_w-1:0]    ptr_r, ptr_n;
    logic [id_w-1:0]    ptr_adv;
    logic [id_w-1:0]    ptr_pick;
    logic [id_w-1:0]    grant_id;
    logic [width_p-1:0] pick;
    logic               any;

    // One-hot to binary; zero when no grant is held.
    always_comb begin
        grant_id = '0;
        for (int k = 0; k < width_p; k++) begin
            if (grant_r[k]) grant_id = grant_id | id_w'(k);
        end
    end

    // Pointer value after the held grant is accepted (one past it, wrapping).
    assign ptr_adv = (grant_id == id_w'(width_p - 1)) ? '0 : grant_id + id_w'(1);

    // The refill pick on an accept already sees the advanced pointer, so the
    // requester just served drops to lowest priority even if it re-requests.
    assign ptr_pick = bus.yumi_i ? ptr_adv : ptr_r;

    bsg_rr_scan_pick #(.width_p(width_p), .id_w(id_w)) pick_u (
        .ptr_i  (ptr_pick),
        .reqs_i (bus.reqs_i),
        .pick_o (pick),
        .any_o  (any)
    );

    always_comb begin
        state_n = state_r;
        grant_n = grant_r;
        ptr_n   = ptr_r;
        if (bus.yumi_i) ptr_n = ptr_adv;
        if (state_r == IDLE || bus.yumi_i) begin
            if (any) begin
                grant_n = pick;
                state_n = OFFER;
            end else begin
                grant_n = '0;
                state_n = IDLE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
            grant_r <= '0;
            ptr_r   <= id_w'(lo_pri_reset_p);
        end else begin
            state_r <= state_n;
            grant_r <= grant_n;
            ptr_r   <= ptr_n;
        end
    end

    assign bus.grants_o   = grant_r;
    assign bus.grant_id_o = grant_id;
    assign bus.grant_v_o  = (state_r == OFFER);

`ifndef SYNTHESIS
    a_param: assert property (@(posedge clk_i) lo_pri_reset_p < width_p);
    a_yumi_v: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        bus.yumi_i |-> (state_r == OFFER));
    a_onehot: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        $onehot0(grant_r));
    a_req_hold: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (state_r == OFFER && !bus.yumi_i) |-> (|(bus.reqs_i & grant_r)));
`endif

endmodule

// File: tb/tb_bsg_rr_scan_arb.sv
module tb_bsg_rr_scan_arb;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    bsg_rr_scan_arb_if #(.width_p(4)) a4 ();
    bsg_rr_scan_arb_if #(.width_p(5)) a5 ();

    bsg_rr_scan_arb #(.width_p(4), .lo_pri_reset_p(0)) dut4 (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (a4.master)
    );

    bsg_rr_scan_arb #(.width_p(5), .lo_pri_reset_p(0)) dut5 (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (a5.master)
    );

    typedef struct {
        logic       rst_n;
        logic [3:0] reqs;
        logic       yumi;
        logic [3:0] g;
        logic       v;
        logic [1:0] id;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Independent reference: linear wrap-around search from ptr.
    function automatic int ref_pick(input int ptr, input logic [4:0] r);
        for (int k = 0; k < 5; k++) begin
            int idx;
            idx = (ptr + k) % 5;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    initial begin
        logic [4:0] r5, one5, exp5;
        logic       y5;
        int         m_ptr, m_gid, m_v, ptr_use, p, old_gid, maxw;
        int         wt [5];

        rst_n     = 1'b0;
        a4.reqs_i = '0;
        a4.yumi_i = 1'b0;
        a5.reqs_i = '0;
        a5.yumi_i = 1'b0;
        one5      = 5'b00001;

        //            rst   reqs     yumi  grants   v     id
        tbl[0]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0};
        tbl[1]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0};
        tbl[2]  = '{1'b1, 4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0};
        tbl[3]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[4]  = '{1'b1, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[5]  = '{1'b1, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[6]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[7]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        // pointer moves to 2, masked set empty -> wrap to 0, then 1
        tbl[8]  = '{1'b1, 4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[9]  = '{1'b1, 4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1};
        // offer of 2 held while requests change
        tbl[10] = '{1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[11] = '{1'b1, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2};
        tbl[12] = '{1'b1, 4'b0110, 1'b0, 4'b0100, 1'b1, 2'd2};
        tbl[13] = '{1'b1, 4'b1110, 1'b0, 4'b0100, 1'b1, 2'd2};
        tbl[14] = '{1'b1, 4'b1111, 1'b0, 4'b0100, 1'b1, 2'd2};
        tbl[15] = '{1'b1, 4'b1111, 1'b0, 4'b0100, 1'b1, 2'd2};
        tbl[16] = '{1'b1, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
        // single requester 3, pointer wraps to 0, then back to idle
        tbl[17] = '{1'b1, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[18] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[19] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};
        tbl[20] = '{1'b1, 4'b1001, 1'b0, 4'b0001, 1'b1, 2'd0};
        // reset mid-offer drops the grant
        tbl[21] = '{1'b0, 4'b1001, 1'b0, 4'b0000, 1'b0, 2'd0};
        tbl[22] = '{1'b1, 4'b0110, 1'b0, 4'b0010, 1'b1, 2'd1};
        tbl[23] = '{1'b1, 4'b0110, 1'b1, 4'b0100, 1'b1, 2'd2};
        // new request arriving with yumi joins the same-cycle pick
        tbl[24] = '{1'b1, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3};

        for (int n = 0; n < NV; n++) begin
            @(negedge clk);
            rst_n     = tbl[n].rst_n;
            a4.reqs_i = tbl[n].reqs;
            a4.yumi_i = tbl[n].yumi;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_grants", n), 32'(a4.grants_o),   32'(tbl[n].g));
            chk($sformatf("v%0d_valid", n),  32'(a4.grant_v_o),  32'(tbl[n].v));
            chk($sformatf("v%0d_id", n),     32'(a4.grant_id_o), 32'(tbl[n].id));
        end

        // Randomised width-5 run against the reference model.
        @(negedge clk);
        a4.reqs_i = '0;
        a4.yumi_i = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        m_gid = 0;
        m_v   = 0;
        r5    = '0;
        for (int k = 0; k < 5; k++) wt[k] = 0;

        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            y5 = (m_v != 0) && ($urandom_range(0, 2) != 0);
            if (y5 && $urandom_range(0, 1) == 1) r5 = r5 & ~(one5 << m_gid);
            if ($urandom_range(0, 2) == 0) r5 = r5 | 5'($urandom_range(0, 31));
            a5.reqs_i = r5;
            a5.yumi_i = y5;
            @(posedge clk);
            old_gid = m_gid;
            ptr_use = m_ptr;
            if (y5) begin
                ptr_use = (m_gid == 4) ? 0 : m_gid + 1;
                m_ptr   = ptr_use;
            end
            if (m_v == 0 || y5) begin
                p = ref_pick(ptr_use, r5);
                if (p >= 0) begin m_v = 1; m_gid = p; end
                else        begin m_v = 0; m_gid = 0; end
            end
            exp5 = (m_v != 0) ? (one5 << m_gid) : 5'b0;
            maxw = 0;
            if (y5) begin
                for (int k = 0; k < 5; k++) begin
                    if (r5[k] && k != old_gid) wt[k]++;
                    else                       wt[k] = 0;
                end
            end
            for (int k = 0; k < 5; k++) begin
                if (!r5[k]) wt[k] = 0;
                if (wt[k] > maxw) maxw = wt[k];
            end
            #1;
            chk($sformatf("rnd%0d_grants", c), 32'(a5.grants_o),   32'(exp5));
            chk($sformatf("rnd%0d_valid", c),  32'(a5.grant_v_o),  32'(m_v));
            chk($sformatf("rnd%0d_id", c),     32'(a5.grant_id_o), 32'(m_gid));
            chk($sformatf("rnd%0d_starve", c), 32'(maxw <= 5),     32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
